cpu_regfile_mp: RTL and testbench

- Parametrised integer register file for the CPU core; successor to the fixed 2-read/1-write combinational-read regfile.
- Generalised in XLEN, register count (RV32I 32 / RV32E 16) and read-port count.
- Synchronous (registered) reads suit block-RAM mapping.
- A post-reset clear sequencer zeroes storage one register per cycle, so storage needs no reset.

---
 rtl/cpu_regfile_mp_if.sv | 25 ++
 rtl/cpu_regfile_mp.sv | 135 +++++++++++++
 tb/tb_cpu_regfile_mp.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_regfile_mp_if.sv
// cpu_regfile_mp_if: read/write bus of the multi-port integer register file.
// master = core side, slave = register file side.
interface cpu_regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREAD = 2
);
    logic [NREAD*5-1:0]    rs_addr;
    logic [NREAD*XLEN-1:0] rs_data;
    logic [NREAD-1:0]      rs_illegal;
    logic [4:0]            rd_addr;
    logic [XLEN-1:0]       rd_data;
    logic                  rd_write_en;
    logic                  wr_illegal;
    logic                  ready;

    modport master (
        output rs_addr, rd_addr, rd_data, rd_write_en,
        input  rs_data, rs_illegal, wr_illegal, ready
    );

    modport slave (
        input  rs_addr, rd_addr, rd_data, rd_write_en,
        output rs_data, rs_illegal, wr_illegal, ready
    );
endinterface

// File: rtl/cpu_regfile_mp.sv
// cpu_regfile_mp: parametrised register file, registered reads, post-reset clear.
// Define CPU_REGFILE_BYPASS_EN for write-first same-address reads (default read-first).
module cpu_regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2
) (
    input  logic              clk,
    input  logic              reset,
    cpu_regfile_mp_if.slave   bus
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [AW-1:0]         cnt;
    logic [XLEN-1:0]       mem [1:NREGS-1];

    logic                  ready_q;
    logic                  wr_ill_q;
    logic [NREAD*XLEN-1:0] rs_data_q;
    logic [NREAD*XLEN-1:0] rs_data_d;
    logic [NREAD-1:0]      rs_ill_q;
    logic [NREAD-1:0]      rs_ill_d;

    logic                  wr_ok;
    logic                  wr_bad;
    logic [AW-1:0]         wr_idx;
    logic [4:0]            ra;
    logic                  byp;

    // Addresses are always 5 bits; anything at or above NREGS is illegal.
    function automatic logic out_of_range(input logic [4:0] a);
        return {1'b0, a} >= 6'(NREGS);
    endfunction

    assign wr_bad = (state == RUN) && bus.rd_write_en
                  && out_of_range(bus.rd_addr);
    assign wr_ok  = (state == RUN) && bus.rd_write_en
                  && !out_of_range(bus.rd_addr)
                  && (bus.rd_addr != 5'd0);
    assign wr_idx = bus.rd_addr[AW-1:0];

    // State and clear counter; counter starts at x1 since x0 is not stored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= AW'(1);
        end else begin
            state <= state_nxt;
            if (state == CLEAR)
                cnt <= cnt + AW'(1);
        end
    end

    // Leave CLEAR after the last register has been zeroed.
    always_comb begin
        state_nxt = state;
        unique case (state)
            CLEAR: begin
                if (cnt == AW'(NREGS - 1))
                    state_nxt = RUN;
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    // Storage: zeroed by the sequencer, then written by the core.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR)
                mem[cnt] <= '0;
            else if (wr_ok)
                mem[wr_idx] <= bus.rd_data;
        end
    end

    // Per-port next read data and illegal flags.
    always_comb begin
        rs_data_d = '0;
        rs_ill_d  = '0;
        ra        = '0;
        byp       = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            ra = bus.rs_addr[5*i +: 5];
`ifdef CPU_REGFILE_BYPASS_EN
            byp = wr_ok && (bus.rd_addr == ra);
`else
            byp = 1'b0;
`endif
            if (state == RUN) begin
                if (out_of_range(ra)) begin
                    rs_ill_d[i] = 1'b1;
                end else if (ra != 5'd0) begin
                    if (byp)
                        rs_data_d[XLEN*i +: XLEN] = bus.rd_data;
                    else
                        rs_data_d[XLEN*i +: XLEN] = mem[ra[AW-1:0]];
                end
            end
        end
    end

    // Registered outputs; ready rises on the first RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rs_data_q <= '0;
            rs_ill_q  <= '0;
            wr_ill_q  <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            rs_data_q <= rs_data_d;
            rs_ill_q  <= rs_ill_d;
            wr_ill_q  <= wr_bad;
            ready_q   <= (state_nxt == RUN);
        end
    end

    assign bus.rs_data    = rs_data_q;
    assign bus.rs_illegal = rs_ill_q;
    assign bus.wr_illegal = wr_ill_q;
    assign bus.ready      = ready_q;

endmodule

// File: tb/tb_cpu_regfile_mp.sv
// tb_cpu_regfile_mp: randomized scoreboard bench, RV32E-sized file with 64-bit data.
// Expected outputs come from an array-based model of the register file rules.
module tb_cpu_regfile_mp;
    localparam int XLEN  = 64;
    localparam int NREGS = 16;
    localparam int NREAD = 3;
    localparam int W     = NREAD * XLEN;

`ifdef CPU_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0]     data;
        logic [NREAD-1:0] ill;
        logic             wi;
        logic             rdy;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    exp_t            sbq[$];
    logic [XLEN-1:0] mregs [0:NREGS-1];
    int              clear_left = 0;
    int              checks = 0;
    int              errors = 0;
    int              cyc_n = 0;

    cpu_regfile_mp_if #(.XLEN(XLEN), .NREAD(NREAD)) bus ();

    cpu_regfile_mp #(
        .XLEN (XLEN),
        .NREGS(NREGS),
        .NREAD(NREAD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference: a plain array plus a count of clear cycles still to go.
    function automatic exp_t model(
        input logic            rst,
        input logic            we,
        input logic [4:0]      wa,
        input logic [XLEN-1:0] wd,
        input logic [NREAD*5-1:0] ra
    );
        exp_t e;
        int   a;
        e = '0;
        if (rst) begin
            clear_left = NREGS - 1;
            for (int k = 0; k < NREGS; k++)
                mregs[k] = '0;
            return e;
        end
        if (clear_left > 0) begin
            clear_left--;
            e.rdy = (clear_left == 0);
            return e;
        end
        e.rdy = 1'b1;
        for (int i = 0; i < NREAD; i++) begin
            a = int'(ra[5*i +: 5]);
            if (a >= NREGS)
                e.ill[i] = 1'b1;
            else if (a != 0)
                e.data[XLEN*i +: XLEN] =
                    (BYP && we && a == int'(wa)) ? wd : mregs[a];
        end
        if (we && int'(wa) >= NREGS)
            e.wi = 1'b1;
        else if (we && wa != 5'd0)
            mregs[int'(wa)] = wd;
        return e;
    endfunction

    function automatic logic [NREAD*5-1:0] rds(input int a0, a1, a2);
        return {5'(a2), 5'(a1), 5'(a0)};
    endfunction

    task automatic cyc(
        input logic            rst,
        input logic            we,
        input logic [4:0]      wa,
        input logic [XLEN-1:0] wd,
        input logic [NREAD*5-1:0] ra
    );
        reset           = rst;
        bus.rd_write_en = we;
        bus.rd_addr     = wa;
        bus.rd_data     = wd;
        bus.rs_addr     = ra;
        sbq.push_back(model(rst, we, wa, wd, ra));
        @(negedge clk);
    endtask

    task automatic rnd_cyc();
        cyc(1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            {$urandom(), $urandom()},
            rds($urandom_range(0, 19), $urandom_range(0, 19),
                $urandom_range(0, 19)));
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (clear_left > 0 && guard < 100) begin
            rnd_cyc();
            guard++;
        end
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h",
                     nm, cyc_n, act, req);
        end
    endtask

    // Monitor: pop one expectation per clock and compare all outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc_n++;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("ready", W'(bus.ready), W'(e.rdy));
                chk("wr_illegal", W'(bus.wr_illegal), W'(e.wi));
                chk("rs_illegal", W'(bus.rs_illegal), W'(e.ill));
                chk("rs_data", bus.rs_data, e.data);
            end
        end
    end

    // Stimulus: directed scenarios interleaved with random traffic.
    initial begin
        reset           = 1'b1;
        bus.rd_write_en = 1'b0;
        bus.rd_addr     = '0;
        bus.rd_data     = '0;
        bus.rs_addr     = '0;

        repeat (3) cyc(1'b1, 1'b0, 5'd0, '0, '0);
        wait_ready();
        cyc(1'b0, 1'b0, 5'd0, '0, rds(1, 15, 0));

        cyc(1'b0, 1'b1, 5'd1, 64'h123456789ABCDEF0, rds(0, 0, 0));
        cyc(1'b0, 1'b0, 5'd0, '0, rds(1, 2, 1));
        cyc(1'b0, 1'b1, 5'd0, 64'hDEADBEEFDEADBEEF, rds(0, 0, 0));
        cyc(1'b0, 1'b0, 5'd0, '0, rds(0, 0, 0));

        cyc(1'b0, 1'b1, 5'd20, 64'h00000000FFFFFFFF, rds(0, 0, 0));
        cyc(1'b0, 1'b0, 5'd0, '0, rds(20, 15, 0));
        cyc(1'b0, 1'b0, 5'd0, '0, rds(31, 16, 1));

        cyc(1'b0, 1'b1, 5'd5, 64'h5555555555555555, rds(0, 0, 0));
        cyc(1'b0, 1'b1, 5'd5, 64'hAAAAAAAAAAAAAAAA, rds(5, 5, 5));
        cyc(1'b0, 1'b0, 5'd0, '0, rds(5, 5, 5));

        repeat (400) rnd_cyc();

        cyc(1'b1, 1'b0, 5'd0, '0, '0);
        repeat (10) rnd_cyc();
        cyc(1'b1, 1'b0, 5'd0, '0, '0);
        wait_ready();
        cyc(1'b0, 1'b0, 5'd0, '0, rds(5, 1, 15));

        cyc(1'b0, 1'b1, 5'd4, 64'hAAAAAAAAAAAAAAAA, rds(0, 0, 0));
        cyc(1'b0, 1'b0, 5'd0, '0, rds(4, 0, 0));
        cyc(1'b1, 1'b0, 5'd0, '0, '0);
        cyc(1'b0, 1'b1, 5'd6, 64'h0123012301230123, rds(6, 4, 0));
        wait_ready();
        cyc(1'b0, 1'b0, 5'd0, '0, rds(4, 6, 0));

        repeat (300) rnd_cyc();

        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0",
                     sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
